// File: rtl/gate_self_test_ctrl_if.sv
// Signal bundle between the self-test sequencer, its front-panel/bench controller and the gate unit.
// start/abort are levels sampled every edge; start is accepted only while idle, done is a one-cycle pulse.
interface gate_self_test_ctrl_if;
    logic       start;
    logic       abort;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic [5:0] dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] fail_vec;
    logic [5:0] fail_mask;

    modport master (
        output start, abort, dut_y,
        input  dut_a, dut_b, dut_c, busy, done, pass, err_count,
               fail_valid, fail_vec, fail_mask
    );

    modport slave (
        input  start, abort, dut_y,
        output dut_a, dut_b, dut_c, busy, done, pass, err_count,
               fail_valid, fail_vec, fail_mask
    );
endinterface

// File: rtl/gate_self_test_ctrl.sv
// Walks all 8 {a,b,c} vectors through the gate unit and checks its six outputs against a golden model.
// Optional first-failure capture is enabled with GATE_SEQ_FAIL_CAPTURE_EN.
module gate_self_test_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_self_test_ctrl_if.slave  bus,
    output logic [1:0]            dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] v_q, v_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic [2:0] abc_q, abc_d;
    logic [5:0] golden;
    logic [5:0] diff;
    logic       start_accept;
    logic       check_fire;

    // Golden bit order: [0]=OR [1]=AND [2]=NAND [3]=XOR [4]=NOT(c) [5]=NOR
    assign golden = {~(v_q[2] | v_q[1]), ~v_q[0], v_q[2] ^ v_q[1],
                     ~(v_q[2] & v_q[1]), v_q[2] & v_q[1], v_q[2] | v_q[1]};
    assign diff         = golden ^ bus.dut_y;
    assign start_accept = (state_q == S_IDLE) && bus.start && !bus.abort;
    assign check_fire   = (state_q == S_CHECK) && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            v_q     <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
            abc_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            abc_q   <= abc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        abc_d   = abc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_accept) begin
                    state_d = S_SETTLE;
                    v_d     = 3'd0;
                    cnt_d   = 4'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                    abc_d   = 3'd0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
                else                      cnt_d   = cnt_q + 4'd1;
            end
            S_CHECK: begin
                if (diff != 6'd0) err_d = err_q + 4'd1;
                if (v_q == 3'd7) begin
                    // Pass reflects the final vector's result, so it uses err_d.
                    state_d = S_DONE;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d = S_SETTLE;
                    v_d     = v_q + 3'd1;
                    abc_d   = v_q + 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                abc_d   = 3'd0;
            end
        endcase
        // Abort wins over everything: results so far are kept, the in-flight check is dropped.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            v_d     = 3'd0;
            cnt_d   = 4'd0;
            err_d   = err_q;
            pass_d  = pass_q;
            abc_d   = 3'd0;
        end
    end

    assign bus.dut_a     = abc_q[2];
    assign bus.dut_b     = abc_q[1];
    assign bus.dut_c     = abc_q[0];
    assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign dbg_state_o   = state_q;

`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic       fv_q;
    logic [2:0] fvec_q;
    logic [5:0] fmask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q    <= 1'b0;
            fvec_q  <= 3'd0;
            fmask_q <= 6'd0;
        end else if (start_accept) begin
            fv_q    <= 1'b0;
            fvec_q  <= 3'd0;
            fmask_q <= 6'd0;
        end else if (check_fire && diff != 6'd0 && !fv_q) begin
            fv_q    <= 1'b1;
            fvec_q  <= v_q;
            fmask_q <= diff;
        end
    end

    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;
    assign bus.fail_mask  = fmask_q;
`else
    assign bus.fail_valid = 1'b0;
    assign bus.fail_vec   = 3'd0;
    assign bus.fail_mask  = 6'd0;
`endif
endmodule

// File: doc/gate_self_test_ctrl.md
# gate_self_test_ctrl

Self-test sequencer for the lab's two-input logic-gate unit (OR, AND, NAND, XOR, NOR on a/b; NOT on c). On a start pulse it drives all 8 combinations of {a,b,c} into the gate unit and waits a programmable settle time. It then samples the six gate outputs, checks them against an internal golden model, and reports pass/fail plus an error count. It sits between a bench or front-panel controller and the gate unit.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles between driving a vector and entering the check cycle; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the run; has priority over start
- dut_a, dut_b, dut_c  out  1 each  registered gate-unit inputs
- dut_y  in  6  gate-unit outputs: [0]=OR, [1]=AND, [2]=NAND, [3]=XOR, [4]=NOT, [5]=NOR
- busy  out  1  high in SETTLE or CHECK
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 if the last completed run had zero errors; held
- err_count  out  4  count of mismatching vectors, 0..8
- fail_valid  out  1  a mismatch has been captured (macro only)
- fail_vec  out  3  {a,b,c} of the first failing vector (macro only)
- fail_mask  out  6  expected XOR observed for that vector (macro only)

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, vector index 0, all outputs 0 (including dut_a/b/c and pass).
- Vector v (3-bit index 0..7) maps to dut_a=v[2], dut_b=v[1], dut_c=v[0].
- Golden model: {~(a|b), ~c, a^b, ~(a&b), a&b, a|b}.
- States:
  - IDLE: start=1 and abort=0 → SETTLE. On that transition: v←0, err_count←0, pass←0, fail_* cleared.
  - SETTLE: lasts SETTLE_CYCLES cycles → CHECK.
  - CHECK: lasts 1 cycle. At its closing edge, dut_y is compared to golden(v); on mismatch err_count+1. Then v=7 → DONE; otherwise v←v+1 and → SETTLE.
  - DONE: lasts 1 cycle; done=1 and pass←(err_count==0), including the final check's result. → IDLE.
- abort=1 in any state except IDLE → IDLE at the next edge.
  - No done pulse; dut_a/b/c←0.
  - err_count and pass keep their values.
- start outside IDLE is ignored; it is not queued.
- dut_a/b/c hold their values in DONE and return to 0 on entry to IDLE.

## Timing
- Each vector occupies SETTLE_CYCLES+1 cycles. dut inputs are stable for that whole window.
- done is high in the cycle beginning 8·(SETTLE_CYCLES+1) edges after the start-accepting edge (16 edges for SETTLE_CYCLES=1).
- busy rises at the edge after start is sampled and falls at the edge entering DONE.
- The error increment and the v advance take effect at the same edge; the last vector's increment is visible in DONE.
- Asynchronous reset during a run → IDLE immediately, all outputs 0.

## Configuration
- GATE_SEQ_FAIL_CAPTURE_EN defined:
  - At the first mismatching CHECK of a run: fail_valid←1, fail_vec←v, fail_mask←golden^dut_y.
  - These are held until the next accepted start or reset. Later mismatches do not overwrite them.
- GATE_SEQ_FAIL_CAPTURE_EN undefined: fail_valid, fail_vec and fail_mask are tied to 0. The ports remain present.

## Test plan
- Correct gate model, SETTLE_CYCLES=1, start pulse → done 16 edges later, pass=1, err_count=0, fail_valid=0.
- OR output stuck at 0 → err_count=6, pass=0; with macro: fail_vec=3'b010, fail_mask=6'b000001.
- NOT output wired as c (non-inverted) → err_count=8; with macro: fail_vec=3'b000, fail_mask=6'b010000.
- abort during vector 3 → IDLE next edge, busy=0, no done, dut_a/b/c=0; a new start then completes with pass=1.
- start re-pulsed while busy, and SETTLE_CYCLES=3 → the second start is ignored, done comes exactly 32 edges after the first start, and each vector is held 4 cycles.
- rst_n asserted mid-run → all outputs 0 asynchronously; after release, start gives a normal complete run.
